seven_seg_scan_n: RTL and testbench
===================================

SEVEN_SEG_SCAN_N -- requirements
Module: seven_seg_scan_n

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, scan-counter width; each digit is shown for 2^DIV_WIDTH clk cycles (DIV_WIDTH >= 4).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 = anode and segment outputs active-low, 0 = active-high.
REQ-004 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-005 SHALL have ports, in this order:
  - clk  in  1  clock
  - rst  in  1  sync reset, active-high
  - data_in  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, k=0 least significant
  - dp_in  in  NUM_DIGITS  decimal-point enable per digit
  - blank_in  in  NUM_DIGITS  force digit k dark
  - lz_en  in  1  leading-zero suppression enable
  - brightness  in  4  duty level, 0 = 1/16 on, 15 = always on
  - load  in  1  single-cycle request to capture data_in/dp_in/blank_in
  - seg  out  8  segments {dp,g,f,e,d,c,b,a}
  - anode  out  NUM_DIGITS  digit enables, one-hot when active
  - frame_done  out  1  one-cycle pulse when the last digit period ends

Function
REQ-006 SHALL hold a free-running DIV_WIDTH-bit tick counter, incrementing every cycle and wrapping to 0.
REQ-007 SHALL advance the digit index on tick wrap: 0,1,...,NUM_DIGITS-1, then 0; digit 0 is first after reset.
REQ-008 SHALL pulse frame_done for one cycle on the cycle where tick wraps with index = NUM_DIGITS-1.
REQ-009 SHALL, on load=1, capture data_in, dp_in and blank_in into shadow registers and set a pending flag.
REQ-010 SHALL copy shadow to display registers only on the frame_done cycle when pending=1, then clear pending (no tearing mid-frame).
REQ-011 SHALL, when load=1 on the frame_done cycle, copy the inputs of that same cycle directly into display registers and leave pending cleared.
REQ-012 SHALL, when load repeats before the frame boundary, keep only the most recent capture.
REQ-013 SHALL decode the display nibble of the current index to segments a..g for hex 0-F; dp follows the display dp bit.
REQ-014 SHALL, with lz_en=1, darken every digit above the most significant non-zero display nibble; digit 0 is never suppressed (all-zero value shows "0").
REQ-015 SHALL darken a digit (anode inactive, segments off) when its display blank bit is 1; blanking does not change the zero-suppression scan.
REQ-016 SHALL drive the current anode active only while tick[DIV_WIDTH-1:DIV_WIDTH-4] <= brightness (unsigned); otherwise all anodes are inactive.
REQ-017 SHALL register seg and anode; both reflect the tick/index state of the previous cycle (1-cycle latency), and are never active for two digits at once.
REQ-018 SHALL drive inactive digits' anode bits to the inactive level (1 if ACTIVE_LOW, else 0); segments follow the same polarity.

Reset
REQ-019 SHALL, on rst=1 at a clk edge: tick=0, index=0, pending=0, shadow and display registers all 0, frame_done=0.
REQ-020 SHALL, during reset, drive all anode bits and all seg bits inactive.
REQ-021 SHALL discard a pending load when rst is asserted mid-frame; load in the reset cycle is ignored.

Structure
REQ-022 SHALL place in shared package seven_seg_pkg: segment bit-index constants, the 16-entry hex-to-segment table (active-high) and the DIV_WIDTH/NUM_DIGITS legal-range constants.
REQ-023 SHALL instantiate one sub-module, seg_hex_decode (4-bit nibble to 7 active-high segments, combinational); polarity inversion is applied in seven_seg_scan_n.

Verification
REQ-024 SHALL cover: NUM_DIGITS=4, DIV_WIDTH=4, brightness=15, load data_in=16'h12AF once -> anode cycles 1110,1101,1011,0111 every 16 cycles, seg showing F,A,2,1 from the first full frame after capture.
REQ-025 SHALL cover: load 16'h0000 then 16'h5555 mid-frame -> display stays 0000 until frame_done, first frame after shows 5555, frame_done pulses exactly once per 64 cycles.
REQ-026 SHALL cover: lz_en=1, data 16'h0030 -> digits 3 and 2 dark, digits 1,0 show 3,0; data 16'h0000 -> only digit 0 shows 0.
REQ-027 SHALL cover: brightness=3, DIV_WIDTH=6 -> each anode active 16 of 64 cycles; brightness=0 -> 4 of 64.
REQ-028 SHALL cover: load on the frame_done cycle with data 16'hBEEF -> next frame shows BEEF; rst asserted with pending load -> all outputs inactive, display 0 after release.
REQ-029 SHALL cover: ACTIVE_LOW=0, blank_in=4'b0100, dp_in=4'b0001 -> anode bit 2 never 1, seg[7]=1 only while digit 0 active.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: segment bit
// positions, the active-high hex glyph table and legal parameter ranges.
package seven_seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam int NUM_DIGITS_MIN = 2;
    localparam int NUM_DIGITS_MAX = 16;
    localparam int DIV_WIDTH_MIN  = 4;

    // Entry n is the {g,f,e,d,c,b,a} pattern for hex digit n, 1 = lit.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seven_seg_scan_n_decode.sv
// Combinational hex nibble to active-high a..g segment decoder.
module seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seven_seg_scan_n.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous
// display update, leading-zero suppression, per-digit blanking and PWM dimming.
module seven_seg_scan_n
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_en,
    input  logic [3:0]              brightness,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int                    IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_WIDTH-1:0]  TICK_MAX = '1;
    localparam logic                  INV      = (ACTIVE_LOW != 0);

    generate
        if (NUM_DIGITS < NUM_DIGITS_MIN || NUM_DIGITS > NUM_DIGITS_MAX ||
            DIV_WIDTH < DIV_WIDTH_MIN) begin : g_bad_cfg
            $error("seven_seg_scan_n: NUM_DIGITS or DIV_WIDTH out of range");
        end
    endgenerate

    logic [DIV_WIDTH-1:0]    r_tick;
    logic [IDX_W-1:0]        r_index;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_shadow_data;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [NUM_DIGITS-1:0]   r_shadow_blank;
    logic [4*NUM_DIGITS-1:0] r_disp_data;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_disp_blank;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_anode;

    logic                    w_tick_wrap;
    logic                    w_frame_end;
    logic [NUM_DIGITS-1:0]   w_zero_from;
    logic [NUM_DIGITS-1:0]   w_dark;
    logic [NUM_DIGITS-1:0]   w_anode_on;
    logic [3:0]              w_cur_nibble;
    logic                    w_cur_dp;
    logic                    w_cur_dark;
    logic                    w_duty_on;
    logic                    w_digit_on;
    logic [6:0]              w_hex_seg;
    logic [7:0]              w_seg_on;

    assign w_tick_wrap = (r_tick == TICK_MAX);
    assign w_frame_end = w_tick_wrap && (r_index == LAST_IDX) && !rst;
    assign frame_done  = w_frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick  <= '0;
            r_index <= '0;
        end else begin
            r_tick <= r_tick + 1'b1;
            if (w_tick_wrap) begin
                r_index <= (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
            end
        end
    end

    // A load landing on the frame boundary bypasses the shadow copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending      <= 1'b0;
            r_shadow_data  <= '0;
            r_shadow_dp    <= '0;
            r_shadow_blank <= '0;
            r_disp_data    <= '0;
            r_disp_dp      <= '0;
            r_disp_blank   <= '0;
        end else begin
            if (load) begin
                r_shadow_data  <= data_in;
                r_shadow_dp    <= dp_in;
                r_shadow_blank <= blank_in;
            end
            if (w_frame_end) begin
                if (load) begin
                    r_disp_data  <= data_in;
                    r_disp_dp    <= dp_in;
                    r_disp_blank <= blank_in;
                end else if (r_pending) begin
                    r_disp_data  <= r_shadow_data;
                    r_disp_dp    <= r_shadow_dp;
                    r_disp_blank <= r_shadow_blank;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // w_zero_from[k]: every display nibble from k upward is zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign w_zero_from[gi] = (r_disp_data[4*gi +: 4] == 4'h0);
            end else begin : g_lower
                assign w_zero_from[gi] = (r_disp_data[4*gi +: 4] == 4'h0) && w_zero_from[gi+1];
            end
            if (gi == 0) begin : g_lsd
                assign w_dark[gi] = r_disp_blank[gi];
            end else begin : g_upper
                assign w_dark[gi] = r_disp_blank[gi] || (lz_en && w_zero_from[gi]);
            end
            assign w_anode_on[gi] = w_digit_on && (r_index == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        w_cur_nibble = 4'h0;
        w_cur_dp     = 1'b0;
        w_cur_dark   = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_index == IDX_W'(k)) begin
                w_cur_nibble = r_disp_data[4*k +: 4];
                w_cur_dp     = r_disp_dp[k];
                w_cur_dark   = w_dark[k];
            end
        end
    end

    seg_hex_decode u_decode (
        .i_nibble (w_cur_nibble),
        .o_seg    (w_hex_seg)
    );

    assign w_duty_on  = (r_tick[DIV_WIDTH-1 -: 4] <= brightness);
    assign w_digit_on = w_duty_on && !w_cur_dark;

    always_comb begin
        w_seg_on = 8'h00;
        if (w_digit_on) begin
            w_seg_on[SEG_G:SEG_A] = w_hex_seg;
            w_seg_on[SEG_DP]      = w_cur_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg   <= {8{INV}};
            r_anode <= {NUM_DIGITS{INV}};
        end else begin
            r_seg   <= w_seg_on ^ {8{INV}};
            r_anode <= w_anode_on ^ {NUM_DIGITS{INV}};
        end
    end

    assign seg   = r_seg;
    assign anode = r_anode;

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Bench for seven_seg_scan_n: three configurations sharing one stimulus,
// a cycle-count reference model for the main instance, table vectors and sequences.
module tb_seven_seg_scan_n;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_en;
    logic [3:0]  brightness;
    logic        load;

    logic [7:0]  seg_a, seg_b, seg_c;
    logic [3:0]  anode_a, anode_b, anode_c;
    logic        fd_a, fd_b, fd_c;

    int n_checks = 0;
    int n_errors = 0;

    seven_seg_scan_n #(.NUM_DIGITS(4), .DIV_WIDTH(4), .ACTIVE_LOW(1)) u_dut_a (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
        .lz_en(lz_en), .brightness(brightness), .load(load),
        .seg(seg_a), .anode(anode_a), .frame_done(fd_a));

    seven_seg_scan_n #(.NUM_DIGITS(4), .DIV_WIDTH(6), .ACTIVE_LOW(1)) u_dut_b (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
        .lz_en(lz_en), .brightness(brightness), .load(load),
        .seg(seg_b), .anode(anode_b), .frame_done(fd_b));

    seven_seg_scan_n #(.NUM_DIGITS(4), .DIV_WIDTH(4), .ACTIVE_LOW(0)) u_dut_c (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
        .lz_en(lz_en), .brightness(brightness), .load(load),
        .seg(seg_c), .anode(anode_c), .frame_done(fd_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state for instance A (4 digits, 16 cycles per digit).
    int          m_cyc;
    logic        m_valid = 1'b0;
    logic        m_pend;
    logic [15:0] m_sh_d, m_ds_d;
    logic [3:0]  m_sh_dp, m_sh_bl, m_ds_dp, m_ds_bl;
    logic [3:0]  exp_an;
    logic [7:0]  exp_sg;

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic            lz;
        logic [3:0][7:0] exp;   // active-high {dp,g..a} per digit, 0 = dark
    } vec_t;

    vec_t vecs [9];

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model one clock edge: outputs come from the pre-edge state.
    task automatic model_edge();
        int tick, idx, msd;
        bit on;
        if (rst) begin
            m_valid = 1'b1;
            m_cyc   = 0;
            m_pend  = 1'b0;
            m_sh_d  = '0; m_sh_dp = '0; m_sh_bl = '0;
            m_ds_d  = '0; m_ds_dp = '0; m_ds_bl = '0;
            exp_an  = 4'hF;
            exp_sg  = 8'hFF;
        end else begin
            tick = m_cyc % 16;
            idx  = m_cyc / 16;
            msd  = 0;
            for (int k = 0; k < 4; k++) if (m_ds_d[4*k +: 4] != 4'h0) msd = k;
            on = !m_ds_bl[idx] && !(lz_en && idx > msd) && (tick <= int'(brightness));
            if (on) begin
                exp_an = ~(4'b0001 << idx);
                exp_sg = ~{m_ds_dp[idx], hex7(m_ds_d[4*idx +: 4])};
            end else begin
                exp_an = 4'hF;
                exp_sg = 8'hFF;
            end
            if (load) begin
                m_sh_d = data_in; m_sh_dp = dp_in; m_sh_bl = blank_in;
            end
            if (m_cyc == 63) begin
                if (load) begin
                    m_ds_d = data_in; m_ds_dp = dp_in; m_ds_bl = blank_in;
                end else if (m_pend) begin
                    m_ds_d = m_sh_d; m_ds_dp = m_sh_dp; m_ds_bl = m_sh_bl;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            m_cyc = (m_cyc + 1) % 64;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (m_valid) begin
            chk("anode_a", 32'(anode_a), 32'(exp_an));
            chk("seg_a", 32'(seg_a), 32'(exp_sg));
            chk("frame_done_a", 32'(fd_a), 32'(!rst && m_cyc == 63));
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        data_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_fd(input int which);
        int n = 0;
        logic f;
        f = (which == 0) ? fd_a : (which == 1) ? fd_b : fd_c;
        while (!f && n < 400) begin
            step();
            n++;
            f = (which == 0) ? fd_a : (which == 1) ? fd_b : fd_c;
        end
        chk("frame_done_seen", 32'(f), 32'd1);
    endtask

    // Call in a frame_done cycle; returns per-digit active-high segments seen.
    task automatic collect_frame(output logic [3:0][7:0] obs);
        obs = '0;
        step();
        repeat (64) begin
            step();
            for (int k = 0; k < 4; k++) if (!anode_a[k]) obs[k] = ~seg_a;
        end
    endtask

    task automatic check_frame(input string name, input logic [3:0][7:0] exp);
        logic [3:0][7:0] obs;
        collect_frame(obs);
        for (int k = 0; k < 4; k++) chk(name, 32'(obs[k]), 32'(exp[k]));
    endtask

    initial begin
        logic [3:0][7:0] all0;
        int cnt, ok, n;
        int act_cnt [4];

        all0 = {8'h3F, 8'h3F, 8'h3F, 8'h3F};
        vecs[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, {8'h06, 8'h5B, 8'h77, 8'h71}};
        vecs[1] = '{16'h5555, 4'h0, 4'h0, 1'b0, {8'h6D, 8'h6D, 8'h6D, 8'h6D}};
        vecs[2] = '{16'h0030, 4'h0, 4'h0, 1'b1, {8'h00, 8'h00, 8'h4F, 8'h3F}};
        vecs[3] = '{16'h0000, 4'h0, 4'h0, 1'b1, {8'h00, 8'h00, 8'h00, 8'h3F}};
        vecs[4] = '{16'hBEEF, 4'h0, 4'h0, 1'b0, {8'h7C, 8'h79, 8'h79, 8'h71}};
        vecs[5] = '{16'h1234, 4'h1, 4'h4, 1'b0, {8'h06, 8'h00, 8'h4F, 8'hE6}};
        vecs[6] = '{16'h0000, 4'h0, 4'h0, 1'b0, {8'h3F, 8'h3F, 8'h3F, 8'h3F}};
        vecs[7] = '{16'h0800, 4'h0, 4'h2, 1'b1, {8'h00, 8'h7F, 8'h00, 8'h3F}};
        vecs[8] = '{16'hC9D6, 4'hA, 4'h0, 1'b0, {8'hB9, 8'h6F, 8'hDE, 8'h7D}};

        rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0;
        lz_en = 1'b0; brightness = 4'hF;
        repeat (3) step();
        chk("reset_anode_b", 32'(anode_b), 32'hF);
        chk("reset_seg_b", 32'(seg_b), 32'hFF);
        chk("reset_anode_c", 32'(anode_c), 32'h0);
        chk("reset_seg_c", 32'(seg_c), 32'h00);
        rst = 1'b0;

        // Table vectors: capture, then inspect the first full frame afterwards.
        for (int i = 0; i < 9; i++) begin
            lz_en = vecs[i].lz;
            do_load(vecs[i].data, vecs[i].dp, vecs[i].blank);
            wait_fd(0);
            check_frame($sformatf("vec%0d_digits", i), vecs[i].exp);
            $display("vector %0d: data=%h dp=%b blank=%b lz=%b", i, vecs[i].data,
                     vecs[i].dp, vecs[i].blank, vecs[i].lz);
        end

        // Mid-frame load must not tear the visible frame.
        lz_en = 1'b0;
        do_load(16'h0000, 4'h0, 4'h0);
        wait_fd(0);
        check_frame("zero_frame", all0);
        repeat (20) step();
        do_load(16'h5555, 4'h0, 4'h0);
        ok = 1; n = 0;
        while (!fd_a && n < 100) begin
            step();
            n++;
            if (anode_a != 4'hF && seg_a != 8'hC0) ok = 0;
        end
        chk("stay_zero_until_frame", 32'(ok), 32'd1);
        check_frame("after_5555", {8'h6D, 8'h6D, 8'h6D, 8'h6D});
        cnt = 0;
        repeat (128) begin
            step();
            if (fd_a) cnt++;
        end
        chk("frame_done_per_128", 32'(cnt), 32'd2);
        $display("sequence: mid-frame load, frame_done count %0d", cnt);

        // Load on the frame_done cycle itself.
        wait_fd(0);
        data_in = 16'hBEEF; dp_in = '0; blank_in = '0; load = 1'b1;
        step();
        load = 1'b0;
        check_frame("load_on_frame_done", {8'h7C, 8'h79, 8'h79, 8'h71});
        $display("sequence: load on frame_done cycle with BEEF");

        // Active-high instance with one blanked digit and a dp on digit 0.
        do_load(16'h1234, 4'b0001, 4'b0100);
        wait_fd(2);
        step();
        act_cnt = '{0, 0, 0, 0};
        repeat (64) begin
            step();
            if (anode_c[2]) act_cnt[0]++;
            if (seg_c[7] && !anode_c[0]) act_cnt[1]++;
            if (seg_c[7] && anode_c[0]) act_cnt[2]++;
        end
        chk("c_anode2_lit", 32'(act_cnt[0]), 32'd0);
        chk("c_dp_without_digit0", 32'(act_cnt[1]), 32'd0);
        chk("c_dp_with_digit0", 32'(act_cnt[2]), 32'd16);
        $display("sequence: active-high blank/dp, dp cycles %0d", act_cnt[2]);

        // Reset with a pending load discards it; reset-cycle load ignored.
        step(); step();
        do_load(16'h7777, 4'hF, 4'h0);
        data_in = 16'h9999; load = 1'b1; rst = 1'b1;
        step();
        chk("rst_anode_b", 32'(anode_b), 32'hF);
        chk("rst_seg_b", 32'(seg_b), 32'hFF);
        chk("rst_frame_done_b", 32'(fd_b), 32'd0);
        chk("rst_anode_c", 32'(anode_c), 32'h0);
        chk("rst_seg_c", 32'(seg_c), 32'h00);
        rst = 1'b0; load = 1'b0;
        step();
        wait_fd(0);
        check_frame("after_reset_zero", all0);
        $display("sequence: reset with pending load");

        // Brightness duty on the 64-cycle-per-digit instance.
        for (int b = 0; b < 2; b++) begin
            brightness = (b == 0) ? 4'd3 : 4'd0;
            act_cnt = '{0, 0, 0, 0};
            repeat (256) begin
                step();
                for (int k = 0; k < 4; k++) if (!anode_b[k]) act_cnt[k]++;
            end
            for (int k = 0; k < 4; k++)
                chk($sformatf("b_duty_br%0d_d%0d", brightness, k), 32'(act_cnt[k]),
                    (b == 0) ? 32'd16 : 32'd4);
            $display("sequence: brightness %0d, digit0 on %0d of 256", brightness, act_cnt[0]);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if (i % 97 == 0) brightness = 4'($urandom_range(0, 15));
            if (i % 150 == 0) lz_en = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 15) == 0);
            data_in  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp_in    = 4'($urandom);
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step();
        end
        load = 1'b0;
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
